pq_arbiter: RTL and testbench

- Shares one priority-queue instance (pq_if device side: enq, deq, kvi, kvo, full, busy, empty) between NREQ independent requesters.
- Arbitration is round-robin and gated on eligibility: enq needs !full; deq and replace need !empty.
- Sequences each operation as issue pulse, wait on busy, then idle. Returns the dequeued or replaced head key to the winner.
- Sits between requester logic (button front-ends, traffic generators) and the queue.

---
 rtl/pq_pkg.sv | 26 ++
 rtl/pq_if.sv | 15 +
 rtl/pq_rr_pick.sv | 32 +++
 rtl/pq_arbiter.sv | 118 +++++++++++
 tb/tb_pq_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared types for the priority-queue arbiter slice
package pq_pkg;

   localparam int KVW = 16;

   typedef logic [KVW-1:0] kv_t;

   typedef enum logic [1:0] {
      NOP = 2'b00,
      ENQ = 2'b01,
      DEQ = 2'b10,
      REP = 2'b11
   } pq_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

   // An op can start only if the queue can absorb (ENQ) or supply (DEQ/REP) a key.
   function automatic logic op_eligible(pq_op_t op, logic full, logic empty);
      return ((op == ENQ) && !full) || (((op == DEQ) || (op == REP)) && !empty);
   endfunction

endpackage

// File: rtl/pq_if.sv
// rtl/pq_if.sv - device-side handshake of one priority-queue instance
interface pq_if;

   logic        enq;
   logic        deq;
   pq_pkg::kv_t kvi;
   pq_pkg::kv_t kvo;
   logic        full;
   logic        empty;
   logic        busy;

   modport master (output enq, deq, kvi, input kvo, full, empty, busy);
   modport slave  (input enq, deq, kvi, output kvo, full, empty, busy);

endinterface

// File: rtl/pq_rr_pick.sv
// rtl/pq_rr_pick.sv - round-robin picker: first set bit after ptr, wrapping modulo N
module pq_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] win
);

   logic [N-1:0] rot;
   int           base;

   always_comb begin
      found = 1'b0;
      win   = '0;
      rot   = '0;
      base  = (int'(ptr) + 1) % N;
      for (int k = 0; k < N; k++) begin
         rot[k] = elig[(base + k) % N];
      end
      // Walk downwards so the lowest rotated position is the last one written.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            win   = IW'((base + k) % N);
         end
      end
   end

endmodule

// File: rtl/pq_arbiter.sv
// rtl/pq_arbiter.sv - round-robin sharing of one priority queue; PQ_ARB_REJECT_EN acks ineligible winners with rsp_err
module pq_arbiter
   import pq_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  pq_op_t [NREQ-1:0]   req_op,
   input  kv_t [NREQ-1:0]      req_kv,
   output logic [NREQ-1:0]     ack,
`ifdef PQ_ARB_REJECT_EN
   output logic                rsp_err,
`endif
   output logic                rsp_valid,
   output logic [IDW-1:0]      rsp_id,
   output kv_t                 rsp_kv,
   pq_if.master                pq
);

   arb_state_t      state;
   logic [IDW-1:0]  rr_ptr;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] cand;
   logic            found;
   logic [IDW-1:0]  win;
   pq_op_t          win_op;
   logic            win_ok;
   logic            win_takes;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_valid[i] && op_eligible(req_op[i], pq.full, pq.empty);
      end
`ifdef PQ_ARB_REJECT_EN
      cand = req_valid;
`else
      cand = elig;
`endif
   end

   pq_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
      .elig  (cand),
      .ptr   (rr_ptr),
      .found (found),
      .win   (win)
   );

   assign win_op    = req_op[win];
   assign win_ok    = elig[win];
   assign win_takes = (win_op == DEQ) || (win_op == REP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= IDW'(NREQ - 1);
         ack       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_kv    <= '0;
         pq.enq    <= 1'b0;
         pq.deq    <= 1'b0;
         pq.kvi    <= '0;
`ifdef PQ_ARB_REJECT_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!pq.busy && found) begin
                  ack    <= NREQ'(1) << win;
                  rr_ptr <= win;
                  state  <= ISSUE;
                  if (win_ok) begin
                     pq.enq <= (win_op == ENQ) || (win_op == REP);
                     pq.deq <= win_takes;
                     pq.kvi <= req_kv[win];
                     // Head is captured before the strobe so it reflects the removed key.
                     if (win_takes) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= win;
                        rsp_kv    <= pq.kvo;
                     end
                  end
`ifdef PQ_ARB_REJECT_EN
                  else begin
                     rsp_err <= 1'b1;
                  end
`endif
               end
            end
            ISSUE: begin
               ack       <= '0;
               rsp_valid <= 1'b0;
               rsp_id    <= '0;
               rsp_kv    <= '0;
               pq.enq    <= 1'b0;
               pq.deq    <= 1'b0;
               pq.kvi    <= '0;
`ifdef PQ_ARB_REJECT_EN
               rsp_err   <= 1'b0;
               state     <= rsp_err ? IDLE : WAIT;
`else
               state     <= WAIT;
`endif
            end
            WAIT: begin
               if (!pq.busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pq_arbiter.sv
// tb/tb_pq_arbiter.sv - randomized scoreboard bench for pq_arbiter with a behavioural queue and arbiter model
module tb_pq_arbiter;
   import pq_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CAP  = 4;
`ifdef PQ_ARB_REJECT_EN
   localparam bit REJ = 1'b1;
`else
   localparam bit REJ = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid;
   pq_op_t [NREQ-1:0] req_op;
   kv_t [NREQ-1:0]    req_kv;
   logic [NREQ-1:0]   ack;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   kv_t               rsp_kv;
`ifdef PQ_ARB_REJECT_EN
   logic              rsp_err;
`endif

   pq_if pq ();

   pq_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_kv    (req_kv),
      .ack       (ack),
`ifdef PQ_ARB_REJECT_EN
      .rsp_err   (rsp_err),
`endif
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_kv    (rsp_kv),
      .pq        (pq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int  cyc;
      int  id;
      bit  enq;
      bit  deq;
      bit  rv;
      bit  err;
      kv_t kvi;
      kv_t rkv;
   } exp_t;

   typedef struct {
      int id;
      int cyc;
   } log_t;

   exp_t sb[$];
   log_t ack_log[$];
   int   checks = 0;
   int   errors = 0;
   int   last_id = -1;
   kv_t  last_rkv = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the expected grant whenever the DUT presents an ack.
   exp_t m_e;
   int   m_id;
   always @(negedge clk) begin
      if (rst) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("ack_timing", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (ack != '0) begin
            m_id = -1;
            for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) m_id = i;
            ack_log.push_back('{m_id, cyc});
            last_id = m_id;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
               chk("unexpected_ack", ack, 0);
            end else begin
               m_e = sb.pop_front();
               chk("ack_onehot", ack, 32'(1) << m_e.id);
               chk("pq_enq", pq.enq, m_e.enq);
               chk("pq_deq", pq.deq, m_e.deq);
               chk("rsp_valid", rsp_valid, m_e.rv);
               if (!m_e.err) chk("pq_kvi", pq.kvi, m_e.kvi);
               if (m_e.rv) begin
                  chk("rsp_id", rsp_id, m_e.id);
                  chk("rsp_kv", rsp_kv, m_e.rkv);
                  last_rkv = rsp_kv;
               end
`ifdef PQ_ARB_REJECT_EN
               chk("rsp_err", rsp_err, m_e.err);
`endif
            end
         end else begin
`ifdef PQ_ARB_REJECT_EN
            chk("idle_outputs", {rsp_err, pq.enq, pq.deq, rsp_valid}, 0);
`else
            chk("idle_outputs", {pq.enq, pq.deq, rsp_valid}, 0);
`endif
         end
      end
   end

   // Requester, queue and arbiter reference state.
   bit     pv[NREQ];
   pq_op_t pop_[NREQ];
   kv_t    pkv[NREQ];
   int     page[NREQ];
   kv_t    qm[$];
   int     busy_left = 0;
   int     busy_len = 0;
   bit     rand_on = 0;
   bit     rand_busy = 0;
   int     mptr = NREQ - 1;
   bit     waiting = 0;
   int     wait_from = 0;
   int     free_from = 0;

   function automatic bit can_go(pq_op_t op, int qsize);
      case (op)
         ENQ:     return qsize < CAP;
         DEQ,
         REP:     return qsize > 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = pv[i];
         req_op[i]    = pop_[i];
         req_kv[i]    = pkv[i];
      end
      pq.busy  = (busy_left > 0);
      pq.full  = (qm.size() >= CAP);
      pq.empty = (qm.size() == 0);
      pq.kvo   = (qm.size() > 0) ? qm[0] : '0;
   endtask

   task automatic setreq(input int i, input pq_op_t op, input kv_t kv);
      pv[i] = 1'b1; pop_[i] = op; pkv[i] = kv; page[i] = 0;
   endtask

   task automatic q_insert(input kv_t v);
      int p = 0;
      while (p < qm.size() && qm[p] <= v) p++;
      qm.insert(p, v);
   endtask

   task automatic step();
      exp_t e;
      int   w;
      bit   wok;
      bit   ok;
      int   idx;
      @(negedge clk);
      if (rst) begin
         if (!waiting && cyc >= free_from && !pq.busy) begin
            w = -1; wok = 0;
            for (int k = 1; k <= NREQ; k++) begin
               idx = (mptr + k) % NREQ;
               ok  = pv[idx] && can_go(pop_[idx], qm.size());
               if (w < 0 && (ok || (REJ && pv[idx]))) begin
                  w = idx; wok = ok;
               end
            end
            if (w >= 0) begin
               e.cyc = cyc + 1; e.id = w; e.err = !wok;
               e.enq = wok && (pop_[w] == ENQ || pop_[w] == REP);
               e.deq = wok && (pop_[w] == DEQ || pop_[w] == REP);
               e.rv  = e.deq;
               e.kvi = pkv[w];
               e.rkv = e.deq ? qm[0] : '0;
               sb.push_back(e);
               mptr  = w;
               pv[w] = 1'b0;
               if (wok) begin
                  waiting = 1; wait_from = cyc + 2;
               end else begin
                  free_from = cyc + 2;
               end
            end
         end
         if (waiting && cyc >= wait_from && !pq.busy) begin
            waiting = 0; free_from = cyc + 1;
         end
         if (pq.enq || pq.deq) begin
            if (pq.deq && qm.size() > 0) void'(qm.pop_front());
            if (pq.enq) q_insert(pq.kvi);
            busy_left = rand_busy ? int'($urandom_range(0, 4)) : busy_len;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (pv[i]) begin
               page[i]++;
               if (page[i] > 60) pv[i] = 1'b0;
            end else if (rand_on && $urandom_range(0, 5) == 0) begin
               setreq(i, ($urandom_range(0, 15) == 0) ? NOP : pq_op_t'(2'($urandom_range(1, 3))),
                      kv_t'($urandom));
            end
         end
      end
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
         apply();
         busy_left--;
      end else begin
         apply();
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_kv}, 0);
      chk({tag, "_strobes"}, {pq.enq, pq.deq}, 0);
      chk({tag, "_kvi"}, pq.kvi, 0);
`ifdef PQ_ARB_REJECT_EN
      chk({tag, "_err"}, rsp_err, 0);
`endif
   endtask

   task automatic model_reset();
      sb.delete();
      waiting = 0;
      mptr    = NREQ - 1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      free_from = cyc;
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 0; pop_[i] = NOP; pkv[i] = '0; page[i] = 0;
      end
      apply();
      #1;
      check_reset_outputs("reset");
      model_reset();
      repeat (2) @(posedge clk);
      release_reset();

      // Four ENQs from reset: served 0..3 on a 3-cycle cadence.
      setreq(0, ENQ, 16'h0010); setreq(1, ENQ, 16'h0020);
      setreq(2, ENQ, 16'h0030); setreq(3, ENQ, 16'h0040);
      apply();
      ack_log.delete();
      run(14);
      chk("t1_count", ack_log.size(), 4);
      for (int i = 0; i < ack_log.size() && i < 4; i++) chk("t1_order", ack_log[i].id, i);
      for (int i = 1; i < ack_log.size() && i < 4; i++)
         chk("t1_gap", ack_log[i].cyc - ack_log[i-1].cyc, 3);

      // DEQ returns the head sampled at grant.
      qm.delete(); qm.push_back(16'h0005);
      setreq(2, DEQ, 16'h0099);
      apply();
      run(6);
      chk("t2_id", last_id, 2);
      chk("t2_rsp_kv", last_rkv, 16'h0005);

      // Full queue: DEQ overtakes the blocked ENQ.
      qm.delete();
      for (int v = 1; v <= 4; v++) qm.push_back(kv_t'(v));
      setreq(0, ENQ, 16'h0050); setreq(1, DEQ, 16'h0051);
      apply();
      ack_log.delete();
      run(10);
`ifndef PQ_ARB_REJECT_EN
      chk("t3_count", ack_log.size(), 2);
      if (ack_log.size() == 2) begin
         chk("t3_first", ack_log[0].id, 1);
         chk("t3_second", ack_log[1].id, 0);
      end
`endif

      // Busy held for 5 cycles stretches the cadence to 8.
      qm.delete();
      busy_len = 5;
      setreq(0, ENQ, 16'h0061); setreq(1, ENQ, 16'h0062);
      apply();
      ack_log.delete();
      run(20);
      chk("t4_count", ack_log.size(), 2);
      if (ack_log.size() == 2) chk("t4_gap", ack_log[1].cyc - ack_log[0].cyc, 8);

      // Reset during WAIT with req3 REP pending; req3 wins after release.
      qm.delete(); qm.push_back(16'h0007);
      busy_len = 10;
      setreq(0, ENQ, 16'h0011);
      apply();
      run(3);
      setreq(3, REP, 16'h0033);
      apply();
      run(2);
      #1 rst = 1'b0;
      #1 check_reset_outputs("wait_reset");
      model_reset();
      pv[0] = 0;
      busy_left = 0;
      busy_len = 0;
      setreq(3, REP, 16'h0033);
      apply();
      release_reset();
      run(6);
      chk("t5_id", last_id, 3);
      chk("t5_rsp_kv", last_rkv, 16'h0007);

`ifdef PQ_ARB_REJECT_EN
      // Empty queue DEQ is rejected; the next grant follows 2 cycles later.
      qm.delete();
      setreq(1, DEQ, 16'h0071); setreq(2, ENQ, 16'h0072);
      apply();
      ack_log.delete();
      run(8);
      chk("t6_count", ack_log.size(), 2);
      if (ack_log.size() == 2) begin
         chk("t6_first", ack_log[0].id, 1);
         chk("t6_second", ack_log[1].id, 2);
         chk("t6_gap", ack_log[1].cyc - ack_log[0].cyc, 2);
      end
`endif

      rand_on = 1; rand_busy = 1;
      run(3000);
      rand_on = 0;
      run(150);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
